// File: rtl/fp_pkg.sv
// fp_pkg -- shared definitions for the floating-point add/sub pipeline.
//
// Holds the default field widths, the bit positions inside the 4-bit flag
// vector {invalid, overflow, underflow, inexact}, and helpers that build
// the canonical quiet NaN and signed infinity for any EXP_W/MAN_W.
// The helpers return a 64-bit word; callers size-cast to their own width.
package fp_pkg;

   localparam int EXP_W_DEF = 8;
   localparam int MAN_W_DEF = 23;

   localparam int FLAG_W         = 4;
   localparam int FLAG_INVALID   = 3;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_INEXACT   = 0;

   // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB only.
   function automatic logic [63:0] qnanWord(input int expW, input int manW);
      logic [63:0] w;
      w = ((64'd1 << expW) - 64'd1) << manW;
      w = w | (64'd1 << (manW - 1));
      return w;
   endfunction

   // Infinity with the requested sign: exponent all ones, fraction zero.
   function automatic logic [63:0] infWord(input logic sign, input int expW, input int manW);
      logic [63:0] w;
      w = ((64'd1 << expW) - 64'd1) << manW;
      w = w | (64'(sign) << (expW + manW));
      return w;
   endfunction

endpackage

// File: rtl/fp_norm_round.sv
// fp_norm_round -- normalise, round-to-nearest-even and pack one result.
//
// Purely combinational; used as the body of the last pipeline stage.
// Ports:
//   sign    in   sign of the larger-magnitude operand
//   effSub  in   1 when the operands had unlike effective signs
//   expIn   in   exponent of the larger-magnitude operand
//   sum     in   MAN_W+5 bits: {carry, hidden, fraction, G, R, S}
//   word    out  packed result {sign, exp, fraction}
//   flags   out  {invalid, overflow, underflow, inexact}
module fp_norm_round
   import fp_pkg::*;
#(
   parameter int EXP_W = EXP_W_DEF,
   parameter int MAN_W = MAN_W_DEF
) (
   input  logic                     sign,
   input  logic                     effSub,
   input  logic [EXP_W-1:0]         expIn,
   input  logic [MAN_W+4:0]         sum,
   output logic [EXP_W+MAN_W:0]     word,
   output logic [FLAG_W-1:0]        flags
);

   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int NW  = MAN_W + 4;          // hidden + fraction + G + R + S
   localparam int LZW = $clog2(NW + 1);
   localparam int EW2 = EXP_W + 2;          // room for +1 and a sign bit
   localparam logic [EW2-1:0] EXP_MAX = EW2'((1 << EXP_W) - 1);

   logic [LZW-1:0]   lz;
   logic             found;
   logic [NW-1:0]    norm;
   logic [EW2-1:0]   expN;
   logic [EW2-1:0]   expF;
   logic [MAN_W:0]   mant;
   logic             g, r, s;
   logic             roundUp;
   logic [MAN_W+1:0] mantR;
   logic [MAN_W-1:0] fracOut;
   logic             tiny;

   // Leading-zero count over everything below the carry bit.
   always_comb begin : lzCount
      lz    = '0;
      found = 1'b0;
      for (int i = NW - 1; i >= 0; i--) begin
         if (!found && sum[i]) begin
            lz    = LZW'(NW - 1 - i);
            found = 1'b1;
         end
      end
   end

   // A carry-out needs one right shift; the dropped bit folds into sticky.
   // Otherwise shift left until the hidden bit is set. Large left shifts
   // only happen after near-total cancellation, where G/R/S are zero.
   always_comb begin : normalise
      if (sum[NW]) begin
         norm = {sum[NW:2], sum[1] | sum[0]};
         expN = {2'b00, expIn} + EW2'(1);
      end else begin
         norm = sum[NW-1:0] << lz;
         expN = {2'b00, expIn} - EW2'(lz);
      end
   end

   always_comb begin : roundRne
      mant    = norm[NW-1:3];
      g       = norm[2];
      r       = norm[1];
      s       = norm[0];
      roundUp = g & (r | s | mant[0]);
      mantR   = {1'b0, mant} + (MAN_W + 2)'(roundUp);
      // Rounding 1.11..1 up gives 10.00..0: fraction zero, exponent + 1.
      if (mantR[MAN_W+1]) begin
         fracOut = '0;
         expF    = expN + EW2'(1);
      end else begin
         fracOut = mantR[MAN_W-1:0];
         expF    = expN;
      end
   end

   // Exponent at or below zero would be subnormal: flush to signed zero.
   assign tiny = expN[EW2-1] | (expN == '0);

   always_comb begin : pack
      word  = '0;
      flags = '0;
      if (sum == '0) begin
         // Cancellation gives +0; adding two zeros keeps their common sign.
         word = {sign & ~effSub, {(W - 1){1'b0}}};
      end else if (tiny) begin
         word                  = {sign, {(W - 1){1'b0}}};
         flags[FLAG_UNDERFLOW] = 1'b1;
         flags[FLAG_INEXACT]   = 1'b1;
      end else if (expF >= EXP_MAX) begin
         word                 = W'(infWord(sign, EXP_W, MAN_W));
         flags[FLAG_OVERFLOW] = 1'b1;
         flags[FLAG_INEXACT]  = 1'b1;
      end else begin
         word                = {sign, expF[EXP_W-1:0], fracOut};
         flags[FLAG_INEXACT] = g | r | s;
      end
   end

endmodule

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe -- three-stage pipelined IEEE-754-style adder/subtractor.
//
// S1: unpack, detect NaN/inf, swap so the larger magnitude is first,
//     align the smaller mantissa with guard/round/sticky.
// S2: add or subtract the aligned mantissas.
// S3: normalise, round to nearest even, pack (fp_norm_round).
// Zero and subnormal inputs count as signed zero; subnormal results flush.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready input handshake for operands a, b and op (1 = a-b)
//   out_valid/out_ready output handshake for result y and flags
//   y                 result word {sign, exp, fraction}
//   flags             {invalid, overflow, underflow, inexact}
//
// Handshake: a word moves across an interface on a rising edge where valid
// and ready are both 1. The producer holds valid and data stable until it
// moves. The whole pipe advances together when the output is empty or
// being taken (advance = !out_valid | out_ready). in_ready is exactly
// advance, so a stalled consumer freezes every stage, y and flags.
module fp_addsub_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W = EXP_W_DEF,
   parameter int MAN_W = MAN_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 op,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] y,
   output logic [FLAG_W-1:0]    flags
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int AW = MAN_W + 3;      // aligned mantissa + G + R
   localparam int MW = MAN_W + 4;      // aligned mantissa + G + R + S
   localparam int SW = MAN_W + 5;      // sum with carry-out
   localparam int WW = 2 * MAN_W + 4;  // shifter: mantissa above a zero field
   localparam logic [W-1:0] QNAN = W'(qnanWord(EXP_W, MAN_W));

   logic advance;

   assign advance  = !out_valid | out_ready;
   assign in_ready = advance;

   // ---------------------------------------------------------------- S1
   logic               signA, signB;
   logic [EXP_W-1:0]   expA, expB;
   logic [MAN_W-1:0]   fracA, fracB;
   logic               nanA, nanB, snanA, snanB, infA, infB, zeroA, zeroB;
   logic [MAN_W:0]     manA, manB;
   logic               aIsLarge;
   logic               signL;
   logic [EXP_W-1:0]   expL, dShift;
   logic [MAN_W:0]     manL, manS;
   logic [WW-1:0]      wide;
   logic [MW-1:0]      alignL, alignS;
   logic               specNow;
   logic [W-1:0]       specWordNow;
   logic [FLAG_W-1:0]  specFlagsNow;

   // Subtraction is addition with b's sign flipped up front.
   assign signA = a[W-1];
   assign signB = b[W-1] ^ op;
   assign expA  = a[W-2:MAN_W];
   assign expB  = b[W-2:MAN_W];
   assign fracA = a[MAN_W-1:0];
   assign fracB = b[MAN_W-1:0];

   assign nanA  = (&expA) & (|fracA);
   assign nanB  = (&expB) & (|fracB);
   assign snanA = nanA & ~fracA[MAN_W-1];
   assign snanB = nanB & ~fracB[MAN_W-1];
   assign infA  = (&expA) & ~(|fracA);
   assign infB  = (&expB) & ~(|fracB);
   assign zeroA = (expA == '0);
   assign zeroB = (expB == '0);

   // Subnormal fractions are discarded, so exp=0 means a mantissa of 0.
   assign manA = zeroA ? '0 : {1'b1, fracA};
   assign manB = zeroB ? '0 : {1'b1, fracB};

   // Exponent then fraction orders the magnitudes of finite operands.
   assign aIsLarge = {expA, manA[MAN_W-1:0]} >= {expB, manB[MAN_W-1:0]};

   always_comb begin : swapAlign
      signL  = aIsLarge ? signA : signB;
      expL   = aIsLarge ? expA : expB;
      manL   = aIsLarge ? manA : manB;
      manS   = aIsLarge ? manB : manA;
      dShift = aIsLarge ? (expA - expB) : (expB - expA);
      wide   = {manS, {AW{1'b0}}} >> dShift;
      alignL = {manL, 3'b000};
      // Past MAN_W+3 positions nothing but the sticky bit can survive.
      if (32'(dShift) >= AW) begin
         alignS = {{AW{1'b0}}, |manS};
      end else begin
         alignS = {wide[WW-1 -: AW], |wide[MAN_W:0]};
      end
   end

   always_comb begin : specials
      specNow      = 1'b0;
      specWordNow  = '0;
      specFlagsNow = '0;
      if (nanA | nanB) begin
         specNow                    = 1'b1;
         specWordNow                = QNAN;
         specFlagsNow[FLAG_INVALID] = snanA | snanB;
      end else if (infA & infB & (signA != signB)) begin
         specNow                    = 1'b1;
         specWordNow                = QNAN;
         specFlagsNow[FLAG_INVALID] = 1'b1;
      end else if (infA) begin
         specNow     = 1'b1;
         specWordNow = {signA, a[W-2:0]};
      end else if (infB) begin
         specNow     = 1'b1;
         specWordNow = {signB, b[W-2:0]};
      end
   end

   logic               s1Valid;
   logic               s1Special;
   logic [W-1:0]       s1SpecWord;
   logic [FLAG_W-1:0]  s1SpecFlags;
   logic               s1Sign, s1Sub;
   logic [EXP_W-1:0]   s1Exp;
   logic [MW-1:0]      s1ManL, s1ManS;

   // ---------------------------------------------------------------- S2
   // The larger operand comes first, so the difference is never negative.
   logic [SW-1:0]      sumNow;

   assign sumNow = s1Sub ? ({1'b0, s1ManL} - {1'b0, s1ManS})
                         : ({1'b0, s1ManL} + {1'b0, s1ManS});

   logic               s2Valid;
   logic               s2Special;
   logic [W-1:0]       s2SpecWord;
   logic [FLAG_W-1:0]  s2SpecFlags;
   logic               s2Sign, s2Sub;
   logic [EXP_W-1:0]   s2Exp;
   logic [SW-1:0]      s2Sum;

   // ---------------------------------------------------------------- S3
   logic [W-1:0]       nrWord;
   logic [FLAG_W-1:0]  nrFlags;

   fp_norm_round #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) uNormRound (
      .sign   (s2Sign),
      .effSub (s2Sub),
      .expIn  (s2Exp),
      .sum    (s2Sum),
      .word   (nrWord),
      .flags  (nrFlags)
   );

   // ------------------------------------------------------- registers
   // Valid bits and the visible result are reset; the datapath is not.
   always_ff @(posedge clk) begin : ctrlRegs
      if (rst) begin
         s1Valid   <= 1'b0;
         s2Valid   <= 1'b0;
         out_valid <= 1'b0;
         y         <= '0;
         flags     <= '0;
      end else if (advance) begin
         s1Valid   <= in_valid;
         s2Valid   <= s1Valid;
         out_valid <= s2Valid;
         if (s2Valid) begin
            y     <= s2Special ? s2SpecWord  : nrWord;
            flags <= s2Special ? s2SpecFlags : nrFlags;
         end
      end
   end

   always_ff @(posedge clk) begin : dataRegs
      if (advance) begin
         s1Special   <= specNow;
         s1SpecWord  <= specWordNow;
         s1SpecFlags <= specFlagsNow;
         s1Sign      <= signL;
         s1Sub       <= signA ^ signB;
         s1Exp       <= expL;
         s1ManL      <= alignL;
         s1ManS      <= alignS;

         s2Special   <= s1Special;
         s2SpecWord  <= s1SpecWord;
         s2SpecFlags <= s1SpecFlags;
         s2Sign      <= s1Sign;
         s2Sub       <= s1Sub;
         s2Exp       <= s1Exp;
         s2Sum       <= sumNow;
      end
   end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe -- directed, table-driven bench for fp_addsub_pipe
// (binary32 defaults). Expected words and flags are hand-computed.
`timescale 1ns/1ps
module tb_fp_addsub_pipe;

   localparam int W = 32;

   // ------------------------------------------------ clock / reset
   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic         op;
   logic [W-1:0] a, b, y;
   logic         out_valid;
   logic         out_ready;
   logic [3:0]   flags;

   always #5 clk = ~clk;

   fp_addsub_pipe #(
      .EXP_W (8),
      .MAN_W (23)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .flags     (flags)
   );

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ------------------------------------------------ vectors
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        op;
      logic [31:0] y;
      logic [3:0]  fl;
   } vecT;

   vecT tbl[22];
   int  nVec = 0;

   task automatic addVec(input logic [31:0] va, input logic [31:0] vb, input logic vop,
                         input logic [31:0] vy, input logic [3:0] vf);
      tbl[nVec] = '{a: va, b: vb, op: vop, y: vy, fl: vf};
      nVec++;
   endtask

   // ------------------------------------------------ scoreboard
   int          total = 0;
   int          bad   = 0;
   int          pendQ[$];
   logic [35:0] expQ[$];
   int          idQ[$];
   bit          stallArm = 1'b0;
   int          stallCnt = 0;

   task automatic check(input string nm, input logic [35:0] act, input logic [35:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, req);
      end
   endtask

   // ------------------------------------------------ driver
   // One clock: drive at the falling edge, look 1ns later (well before the
   // next rising edge), retire an output and/or accept an input.
   task automatic runCycle(input logic ordy);
      @(negedge clk);
      if (stallArm && out_valid) begin
         stallArm = 1'b0;
         stallCnt = 3;
      end
      out_ready = (stallCnt > 0) ? 1'b0 : ordy;
      if (pendQ.size() > 0) begin
         in_valid = 1'b1;
         a        = tbl[pendQ[0]].a;
         b        = tbl[pendQ[0]].b;
         op       = tbl[pendQ[0]].op;
      end else begin
         in_valid = 1'b0;
         a        = $urandom;
         b        = $urandom;
         op       = 1'($urandom_range(0, 1));
      end
      #1;
      if (stallCnt > 0) begin
         check("bp_in_ready", 36'(in_ready), 36'd0);
         check("bp_out_valid", 36'(out_valid), 36'd1);
         if (expQ.size() > 0) check("bp_y_hold", {flags, y}, expQ[0]);
         stallCnt--;
      end
      if (out_valid && out_ready) begin
         if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got %h want no result", {flags, y});
         end else begin
            int id;
            id = idQ.pop_front();
            check($sformatf("vec%0d", id), {flags, y}, expQ.pop_front());
         end
      end
      if (in_valid && in_ready) begin
         int k;
         k = pendQ.pop_front();
         expQ.push_back({tbl[k].fl, tbl[k].y});
         idQ.push_back(k);
      end
   endtask

   task automatic drain(input bit randReady, output int cyc);
      cyc = 0;
      while ((pendQ.size() > 0 || expQ.size() > 0) && cyc < 400) begin
         runCycle(randReady ? 1'($urandom_range(0, 1)) : 1'b1);
         cyc++;
      end
      if (pendQ.size() > 0 || expQ.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: pending=%0d outstanding=%0d want 0 0",
                  pendQ.size(), expQ.size());
         pendQ.delete();
         expQ.delete();
         idQ.delete();
      end
   endtask

   // Send one vector into an empty pipe and check the 3-cycle latency.
   task automatic latencyRun(input int idx, input string tag);
      pendQ.push_back(idx);
      runCycle(1'b1);
      check({tag, "_accept"}, 36'(pendQ.size()), 36'd0);
      for (int k = 1; k <= 3; k++) begin
         runCycle(1'b1);
         check($sformatf("%s_ov_c%0d", tag, k), 36'(out_valid), 36'(k == 3));
      end
      check({tag, "_retired"}, 36'(expQ.size()), 36'd0);
   endtask

   // ------------------------------------------------ test
   initial begin : main
      int cyc;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op        = 1'b0;
      a         = '0;
      b         = '0;

      //        a             b             op    y             {inv,ovf,unf,inx}
      addVec(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000); // 0  1+1
      addVec(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000); // 1  1-1
      addVec(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101); // 2  max+max
      addVec(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000); // 3  inf-inf
      addVec(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000); // 4  qNaN
      addVec(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001); // 5  tie even
      addVec(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001); // 6  tie odd
      addVec(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000); // 7  inf-inf op
      addVec(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000); // 8  sNaN
      addVec(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000); // 9  inf+1
      addVec(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000); // 10 1-2
      addVec(32'h40400000, 32'hBF800000, 1'b0, 32'h40000000, 4'b0000); // 11 3+(-1)
      addVec(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000); // 12 subnormal in
      addVec(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000); // 13 -0+-0
      addVec(32'h00800001, 32'h80800000, 1'b0, 32'h00000000, 4'b0011); // 14 flush
      addVec(32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 4'b0101); // 15 round ovf
      addVec(32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0001); // 16 round carry
      addVec(32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0001); // 17 sticky only
      addVec(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000); // 18 -inf+1
      addVec(32'h3F800000, 32'h3FC00000, 1'b1, 32'hBF000000, 4'b0000); // 19 1-1.5
      addVec(32'hC0000000, 32'h40000000, 1'b0, 32'h00000000, 4'b0000); // 20 -2+2
      addVec(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001); // 21 above tie

      // Reset state.
      repeat (3) @(negedge clk);
      #1;
      check("reset_out_valid", 36'(out_valid), 36'd0);
      check("reset_y", 36'(y), 36'd0);
      check("reset_flags", 36'(flags), 36'd0);
      rst = 1'b0;

      // Latency of a single transfer.
      latencyRun(0, "lat");

      // Full table back-to-back: one result per cycle, in order.
      for (int i = 0; i < nVec; i++) pendQ.push_back(i);
      drain(1'b0, cyc);
      check("throughput_cycles", 36'(cyc), 36'(nVec + 3));

      // Full table again with a randomly stalling consumer.
      for (int i = 0; i < nVec; i++) pendQ.push_back(i);
      drain(1'b1, cyc);

      // Back-pressure: consumer holds off for 3 cycles once a result shows.
      pendQ.push_back(0);
      pendQ.push_back(5);
      pendQ.push_back(6);
      pendQ.push_back(10);
      pendQ.push_back(11);
      pendQ.push_back(16);
      stallArm = 1'b1;
      drain(1'b0, cyc);
      check("bp_stall_seen", 36'(stallArm), 36'd0);

      // Reset with three transfers in flight; none may come out.
      pendQ.push_back(2);
      pendQ.push_back(3);
      pendQ.push_back(6);
      repeat (3) runCycle(1'b1);
      @(negedge clk);
      rst       = 1'b1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a         = tbl[0].a;
      b         = tbl[0].b;
      op        = tbl[0].op;
      @(negedge clk);
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      check("rst_out_valid", 36'(out_valid), 36'd0);
      check("rst_y", 36'(y), 36'd0);
      check("rst_flags", 36'(flags), 36'd0);
      pendQ.delete();
      expQ.delete();
      idQ.delete();
      for (int k = 0; k < 6; k++) begin
         runCycle(1'b1);
         check($sformatf("rst_ghost%0d", k), 36'(out_valid), 36'd0);
      end
      latencyRun(6, "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
